sfx_scheduler: RTL and testbench
================================

# sfx_scheduler

Sound-effect scheduler that sequences the shared audio sample ROM and feeds a duty-cycle value to the downstream PWM stage. Up to NUM_REQ game-logic requesters fire one-cycle play requests. The block latches them, grants the highest-priority one, and steps the ROM address from that clip's start address to its end address at one sample per sample period. A higher-priority request preempts the current clip at the next sample boundary.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; index NUM_REQ-1 has the highest priority.
- ADDR_W, 12: ROM address width.
- PERIOD_W, 32: sample-period counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  one-cycle play-request pulses, one bit per requester.
- clip_start  in  NUM_REQ*ADDR_W  flattened per-requester clip start addresses; slot i is bits [i*ADDR_W +: ADDR_W].
- clip_end  in  NUM_REQ*ADDR_W  flattened per-requester clip end addresses (inclusive).
- period  in  PERIOD_W  sample period in clocks minus one; values below 2 are treated as 2.
- mute  in  1  forces duty to 0; sequencing continues.
- rom_addr  out  ADDR_W  address to the synchronous ROM, which has 1-cycle read latency.
- rom_data  in  8  ROM read data.
- duty  out  8  sample value for the PWM comparator.
- audio_en  out  1  high while a clip is playing; the downstream PWM uses it as its enable.
- busy  out  1  state is not IDLE.
- active_id  out  $clog2(NUM_REQ)  index of the requester currently granted.
- done  out  1  one-cycle pulse when a clip plays to its end without being preempted.

## Operation
- pending[NUM_REQ-1:0] register:
  - req[i] sets bit i.
  - Entering START for id i clears bit i.
  - If req[i] arrives in the same cycle as the clear, the set wins.
- Priority: the winner is the highest-index set bit of pending.
- States:
  - IDLE:
    - Outputs: audio_en=0, duty=0.
    - If pending≠0, go to START.
  - START (1 cycle):
    - active_id <= winner.
    - rom_addr <= clip_start[winner].
    - cnt <= 0.
    - Clear pending[winner].
    - Go to PLAY.
  - PLAY:
    - audio_en=1 and cnt increments each cycle.
    - At cnt==1, duty <= (mute ? 0 : rom_data).
    - At cnt==eff_period (sample boundary), cnt <= 0, then the first matching rule applies:
      - If rom_addr >= clip_end[active_id]: pulse done, then go to START if pending≠0, else IDLE.
      - Else if the winner index >= active_id: go to START. This is a preemption; a re-request of the active id restarts the clip. No done pulse.
      - Else rom_addr <= rom_addr+1.
- eff_period = max(period, 2). period is sampled every cycle, so a change takes effect at the current comparison.
- If clip_start > clip_end, one sample plays, then the clip ends normally.
- Address arithmetic is ADDR_W bits wide; rom_addr never increments past clip_end.
- mute only gates the duty load; while mute=1, duty is loaded as 0.
- Lower-priority requests that arrive during a clip stay pending and play after it finishes.

## Timing
- Reset (rst_n=0 at a clk edge) forces these values regardless of state, including mid-clip:
  - state=IDLE, pending=0, rom_addr=0, cnt=0.
  - duty=0, audio_en=0, busy=0, active_id=0, done=0.
- Latency from a req pulse (state IDLE) to audio_en=1 is 3 edges: the pending set, START, then PLAY.
- The first duty value of a clip is visible from cycle cnt==2 of the first sample.
- Each sample lasts eff_period+1 cycles.
- done is asserted for exactly 1 cycle, on the cycle after the final sample boundary.
- duty holds its last value while in START, returns to 0 in IDLE, and goes to 0 on the first cycle mute is seen in PLAY.
- A req on the same cycle as a sample boundary is not seen by that boundary's decision; it is considered at the next boundary.

## Test plan
- Single clip: period=9, clip_start[0]=44, clip_end[0]=47, pulse req[0].
  - rom_addr steps 44,45,46,47 at 10-cycle intervals.
  - duty follows rom_data with 1-cycle lag at cnt==1.
  - done pulses once, then the block returns to IDLE with audio_en=0.
- Preemption: during clip 0 at address 45, pulse req[2].
  - At the next boundary: START with active_id=2, rom_addr=clip_start[2], no done for clip 0.
  - Clip 0 does not resume (its pending bit is already clear).
- Queueing: during clip 2, pulse req[1] and req[0].
  - After clip 2 ends (done), clip 1 plays, then clip 0, with no IDLE between them.
- Restart: re-pulse req[1] while clip 1 is active → clip 1 restarts from clip_start[1] at the next boundary.
- Edge cases:
  - period=0 → sample length 3 cycles.
  - clip_start=10, clip_end=5 → one sample at address 10, then done.
  - mute=1 mid-clip → duty=0 while addresses keep advancing.
- Reset mid-clip: with state PLAY and pending=4'b0011, drive rst_n=0 for 1 cycle.
  - All outputs reach their reset values on the next edge.
  - pending is cleared and no clip resumes.

Source files
------------

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches play requests, grants the highest-priority clip,
// steps the sample ROM address once per sample period and registers duty for the PWM.
module sfx_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   clip_start,
  input  logic [NUM_REQ*ADDR_W-1:0]   clip_end,
  input  logic [PERIOD_W-1:0]         period,
  input  logic                        mute,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [7:0]                  rom_data,
  output logic [7:0]                  duty,
  output logic                        audio_en,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  active_id,
  output logic                        done
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [NUM_REQ-1:0]  pending, pending_nx, clear_mask;
  logic [ID_W-1:0]     winner, active_id_nx;
  logic [ADDR_W-1:0]   addr_nx, start_sel, end_sel;
  logic [PERIOD_W-1:0] cnt, cnt_nx, eff_period;
  logic [7:0]          duty_nx;
  logic                done_nx;

  // Highest set pending bit wins.
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pending[i]) winner = ID_W'(i);
    end
  end

  assign start_sel  = clip_start[winner*ADDR_W +: ADDR_W];
  assign end_sel    = clip_end[active_id*ADDR_W +: ADDR_W];
  assign eff_period = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;

  always_comb begin
    state_nx     = state;
    clear_mask   = '0;
    addr_nx      = rom_addr;
    cnt_nx       = cnt;
    duty_nx      = duty;
    active_id_nx = active_id;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        duty_nx = 8'd0;
        if (|pending) state_nx = START;
      end
      START: begin
        active_id_nx       = winner;
        addr_nx            = start_sel;
        cnt_nx             = '0;
        clear_mask[winner] = 1'b1;
        state_nx           = PLAY;
      end
      PLAY: begin
        cnt_nx = cnt + PERIOD_W'(1);
        if (mute) duty_nx = 8'd0;
        else if (cnt == PERIOD_W'(1)) duty_nx = rom_data;
        // Sample boundary; >= keeps a mid-sample period reduction from running away.
        if (cnt >= eff_period) begin
          cnt_nx = '0;
          if (rom_addr >= end_sel) begin
            done_nx = 1'b1;
            if (|pending) begin
              state_nx = START;
            end else begin
              state_nx = IDLE;
              duty_nx  = 8'd0;
            end
          end else if ((|pending) && (winner >= active_id)) begin
            state_nx = START;
          end else begin
            addr_nx = rom_addr + ADDR_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // A request landing on the clearing cycle survives.
    pending_nx = (pending & ~clear_mask) | req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      rom_addr  <= '0;
      cnt       <= '0;
      duty      <= 8'd0;
      audio_en  <= 1'b0;
      busy      <= 1'b0;
      active_id <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      rom_addr  <= addr_nx;
      cnt       <= cnt_nx;
      duty      <= duty_nx;
      audio_en  <= (state_nx == PLAY);
      busy      <= (state_nx != IDLE);
      active_id <= active_id_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios plus random requests, every cycle
// compared against a clip-level behavioural model.
module tb_sfx_scheduler;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned PERIOD_W = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] clip_start, clip_end;
  logic [PERIOD_W-1:0]       period;
  logic                      mute;
  logic [ADDR_W-1:0]         rom_addr;
  logic [7:0]                rom_data;
  logic [7:0]                duty;
  logic                      audio_en, busy, done;
  logic [1:0]                active_id;

  logic [ADDR_W-1:0] cs [NUM_REQ];
  logic [ADDR_W-1:0] ce [NUM_REQ];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  sfx_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .clip_start(clip_start), .clip_end(clip_end),
    .period(period), .mute(mute), .rom_addr(rom_addr), .rom_data(rom_data),
    .duty(duty), .audio_en(audio_en), .busy(busy), .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    clip_start = '0;
    clip_end   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      clip_start[i*ADDR_W +: ADDR_W] = cs[i];
      clip_end[i*ADDR_W +: ADDR_W]   = ce[i];
    end
  end

  function automatic logic [7:0] rom_fn(input logic [ADDR_W-1:0] a);
    return 8'((32'(a) * 37) + 11);
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: mode 0=idle, 1=granting, 2=playing; pos = cycle within sample.
  int          m_mode = 0;
  logic [3:0]  m_pend = '0;
  logic [11:0] m_addr = '0;
  longint      m_pos = 0;
  logic [7:0]  m_duty = '0;
  int          m_id = 0;
  bit          m_done = 0, m_aud = 0, m_busy = 0;

  always @(posedge clk) begin
    int     top;
    longint len;
    logic [3:0] served;
    top = -1;
    for (int i = 0; i < NUM_REQ; i++) if (m_pend[i]) top = i;
    len = (period < 2) ? 2 : longint'(period);
    served = '0;
    m_done = 0;
    if (!rst_n) begin
      m_mode = 0; m_pend = '0; m_addr = '0; m_pos = 0; m_duty = '0; m_id = 0;
      m_aud = 0; m_busy = 0;
    end else begin
      if (m_mode == 0) begin
        m_duty = 0;
        if (top >= 0) m_mode = 1;
      end else if (m_mode == 1) begin
        m_id = top; m_addr = cs[top]; m_pos = 0; served[top] = 1'b1; m_mode = 2;
      end else begin
        if (mute) m_duty = 0;
        else if (m_pos == 1) m_duty = rom_fn(m_addr);
        if (m_pos == len) begin
          m_pos = 0;
          if (m_addr >= ce[m_id]) begin
            m_done = 1;
            if (top >= 0) m_mode = 1;
            else begin m_mode = 0; m_duty = 0; end
          end else if (top >= m_id) m_mode = 1;
          else m_addr = m_addr + 12'd1;
        end else m_pos = m_pos + 1;
      end
      m_pend = (m_pend & ~served) | req;
      m_aud  = (m_mode == 2);
      m_busy = (m_mode != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
      check_eq("duty", 32'(duty), 32'(m_duty));
      check_eq("audio_en", 32'(audio_en), 32'(m_aud));
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("active_id", 32'(active_id), 32'(m_id));
      check_eq("done", 32'(done), 32'(m_done));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int id);
    req[id] = 1'b1;
    tick();
    req = '0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int c = 0;
    while ((m_mode != 0 || m_pend != 0) && c < max_cyc) begin tick(); c++; end
    check_eq("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_play(input int id, input int addr, input int max_cyc);
    int c = 0;
    while (!(m_mode == 2 && m_id == id && (addr < 0 || int'(m_addr) == addr)) && c < max_cyc) begin
      tick(); c++;
    end
    check_eq("wait_play_id", 32'(active_id), 32'(id));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; period = 32'd9; mute = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin cs[i] = '0; ce[i] = '0; end
    cs[0] = 12'd44;  ce[0] = 12'd47;
    cs[1] = 12'd300; ce[1] = 12'd302;
    cs[2] = 12'd200; ce[2] = 12'd203;
    cs[3] = 12'd500; ce[3] = 12'd510;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Single clip, then preemption and queueing.
    pulse(0);
    wait_idle(100);
    pulse(0);
    wait_play(0, 45, 100);
    pulse(2);
    wait_play(2, -1, 30);
    pulse(1);
    pulse(0);
    wait_idle(400);

    // Restart of the active clip.
    pulse(1);
    tick(15);
    pulse(1);
    wait_idle(200);

    // Minimum period and reversed clip bounds.
    period = 32'd0; cs[3] = 12'd10; ce[3] = 12'd5;
    pulse(3);
    wait_idle(50);

    // Mute mid-clip.
    period = 32'd3; cs[1] = 12'd20; ce[1] = 12'd27;
    pulse(1);
    tick(9);
    mute = 1'b1;
    tick(10);
    mute = 1'b0;
    wait_idle(100);

    // Reset while playing with requests 0 and 1 pending.
    period = 32'd9; cs[3] = 12'd500; ce[3] = 12'd510;
    pulse(3);
    wait_play(3, -1, 20);
    pulse(0);
    pulse(1);
    tick(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(40);
    check_eq("post_reset_audio_en", 32'(audio_en), 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) req[i] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) begin
        int s;
        s = $urandom_range(0, NUM_REQ - 1);
        cs[s] = ADDR_W'($urandom_range(0, 4095));
        ce[s] = ($urandom_range(0, 7) == 0) ? cs[s] - 12'd1 : cs[s] + ADDR_W'($urandom_range(0, 3));
      end
      if (m_mode == 0) period = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    req = '0; rst_n = 1'b1; mute = 1'b0;
    wait_idle(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
